// File: rtl/cpu_6502_ISA_pkg.sv
// Shared 6502 ISA definitions: fetch sequencer states, opcode field
// positions and the addressing-mode encodings of the three opcode groups.
package cpu_6502_ISA_pkg;

    typedef enum logic [2:0] {
        REQ_OP,
        WAIT_OP,
        REQ_LO,
        WAIT_LO,
        REQ_HI,
        WAIT_HI,
        ISSUE,
        DRAIN
    } fetch_state_t;

    // Opcode field positions: aaa bbb cc
    localparam int CC_LSB  = 0;
    localparam int CC_MSB  = 1;
    localparam int BBB_LSB = 2;
    localparam int BBB_MSB = 4;
    localparam int AAA_LSB = 5;
    localparam int AAA_MSB = 7;

    // Conditional branches are xxx10000
    localparam logic [7:0] BRANCH_MASK = 8'h1F;
    localparam logic [7:0] BRANCH_VAL  = 8'h10;
    localparam logic [7:0] JSR         = 8'h20;

    localparam logic [1:0] CC_G1 = 2'b01;
    localparam logic [1:0] CC_G2 = 2'b10;
    localparam logic [1:0] CC_G3 = 2'b00;

    // Group 1 (cc=01) addressing modes
    localparam logic [2:0] G1_IND1_ZPG_X = 3'b000;
    localparam logic [2:0] G1_ZPG        = 3'b001;
    localparam logic [2:0] G1_IMM        = 3'b010;
    localparam logic [2:0] G1_ABS        = 3'b011;
    localparam logic [2:0] G1_IND2_ZPG_Y = 3'b100;
    localparam logic [2:0] G1_ZPG_X      = 3'b101;
    localparam logic [2:0] G1_ABS_Y      = 3'b110;
    localparam logic [2:0] G1_ABS_X      = 3'b111;

    // Group 2 (cc=10) addressing modes
    localparam logic [2:0] G2_IMM   = 3'b000;
    localparam logic [2:0] G2_ZPG   = 3'b001;
    localparam logic [2:0] G2_ACC   = 3'b010;
    localparam logic [2:0] G2_ABS   = 3'b011;
    localparam logic [2:0] G2_ZPG_X = 3'b101;
    localparam logic [2:0] G2_ABS_X = 3'b111;

    // Group 3 (cc=00) addressing modes
    localparam logic [2:0] G3_IMM   = 3'b000;
    localparam logic [2:0] G3_ZPG   = 3'b001;
    localparam logic [2:0] G3_ABS   = 3'b011;
    localparam logic [2:0] G3_ZPG_X = 3'b101;
    localparam logic [2:0] G3_ABS_X = 3'b111;

    // Only LDX owns the group 2 immediate slot
    localparam logic [2:0] AAA_LDX = 3'b101;

    // Single-byte opcodes whose encoding does not follow the group tables
    function automatic logic is_implicit(input logic [7:0] op);
        case (op)
            8'h00, 8'h40, 8'h60,
            8'h08, 8'h18, 8'h28, 8'h38, 8'h48, 8'h58, 8'h68, 8'h78,
            8'h88, 8'h98, 8'hA8, 8'hB8, 8'hC8, 8'hD8, 8'hE8, 8'hF8,
            8'h8A, 8'h9A, 8'hAA, 8'hBA, 8'hCA, 8'hEA: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_6502_opcode_length.sv
// Opcode classifier: instruction length in bytes and illegal flag.
module cpu_6502_opcode_length
    import cpu_6502_ISA_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len,
    output logic       illegal
);

    logic [1:0] cc;
    logic [2:0] bbb;
    logic [2:0] aaa;

    assign cc  = opcode[CC_MSB:CC_LSB];
    assign bbb = opcode[BBB_MSB:BBB_LSB];
    assign aaa = opcode[AAA_MSB:AAA_LSB];

    // Implicit list first, then JSR and branches, then the group tables
    always_comb begin
        len     = 2'd1;
        illegal = 1'b1;
        if (is_implicit(opcode)) begin
            illegal = 1'b0;
        end else if (opcode == JSR) begin
            len     = 2'd3;
            illegal = 1'b0;
        end else if ((opcode & BRANCH_MASK) == BRANCH_VAL) begin
            len     = 2'd2;
            illegal = 1'b0;
        end else begin
            case (cc)
                CC_G1: begin
                    illegal = 1'b0;
                    case (bbb)
                        G1_ABS, G1_ABS_Y, G1_ABS_X:          len = 2'd3;
                        G1_IND1_ZPG_X, G1_ZPG, G1_IMM,
                        G1_IND2_ZPG_Y, G1_ZPG_X:             len = 2'd2;
                        default:                             len = 2'd2;
                    endcase
                end
                CC_G2: begin
                    case (bbb)
                        G2_ACC: begin
                            illegal = 1'b0;
                        end
                        G2_IMM: begin
                            if (aaa == AAA_LDX) begin
                                len     = 2'd2;
                                illegal = 1'b0;
                            end
                        end
                        G2_ZPG, G2_ZPG_X: begin
                            len     = 2'd2;
                            illegal = 1'b0;
                        end
                        G2_ABS, G2_ABS_X: begin
                            len     = 2'd3;
                            illegal = 1'b0;
                        end
                        default: ;
                    endcase
                end
                CC_G3: begin
                    case (bbb)
                        G3_IMM, G3_ZPG, G3_ZPG_X: begin
                            len     = 2'd2;
                            illegal = 1'b0;
                        end
                        G3_ABS, G3_ABS_X: begin
                            len     = 2'd3;
                            illegal = 1'b0;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cpu_6502_fetch_sequencer.sv
// 6502 instruction fetch front end: fetches opcode and operand bytes over
// a single-outstanding byte port and hands complete instructions to decode.
module cpu_6502_fetch_sequencer
    import cpu_6502_ISA_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h8000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [7:0]        mem_rdata_i,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    output logic [7:0]        dec_opcode_o,
    output logic [15:0]       dec_operand_o,
    output logic [1:0]        dec_len_o,
    output logic [ADDR_W-1:0] dec_pc_o,
    output logic              dec_illegal_o,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [7:0]        lo_q, lo_d;
    logic [7:0]        hi_q, hi_d;
    logic [1:0]        len_q, len_d;
    logic              illegal_q, illegal_d;

    logic [1:0]        op_len;
    logic              op_illegal;
    logic              req_state;
    logic [ADDR_W-1:0] req_addr;

    cpu_6502_opcode_length u_opcode_length (
        .opcode  (mem_rdata_i),
        .len     (op_len),
        .illegal (op_illegal)
    );

    // State and instruction registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= REQ_OP;
            pc_q      <= RESET_PC;
            opcode_q  <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            len_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            len_q     <= len_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state: redirect overrides everything; a granted but unreturned
    // read must be drained so its late data is not mistaken for new bytes
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        len_d     = len_q;
        illegal_d = illegal_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
            case (state_q)
                REQ_OP, REQ_LO, REQ_HI:    state_d = mem_gnt_i    ? DRAIN  : REQ_OP;
                WAIT_OP, WAIT_LO, WAIT_HI: state_d = mem_rvalid_i ? REQ_OP : DRAIN;
                DRAIN:                     state_d = mem_rvalid_i ? REQ_OP : DRAIN;
                default:                   state_d = REQ_OP;
            endcase
        end else begin
            case (state_q)
                REQ_OP: if (mem_gnt_i) state_d = WAIT_OP;
                REQ_LO: if (mem_gnt_i) state_d = WAIT_LO;
                REQ_HI: if (mem_gnt_i) state_d = WAIT_HI;
                WAIT_OP: begin
                    if (mem_rvalid_i) begin
                        opcode_d  = mem_rdata_i;
                        len_d     = op_len;
                        illegal_d = op_illegal;
                        lo_d      = '0;
                        hi_d      = '0;
                        state_d   = (op_len == 2'd1) ? ISSUE : REQ_LO;
                    end
                end
                WAIT_LO: begin
                    if (mem_rvalid_i) begin
                        lo_d    = mem_rdata_i;
                        state_d = (len_q == 2'd3) ? REQ_HI : ISSUE;
                    end
                end
                WAIT_HI: begin
                    if (mem_rvalid_i) begin
                        hi_d    = mem_rdata_i;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (dec_ready_i) begin
                        pc_d    = pc_q + ADDR_W'(len_q);
                        state_d = REQ_OP;
                    end
                end
                DRAIN: if (mem_rvalid_i) state_d = REQ_OP;
                default: state_d = REQ_OP;
            endcase
        end
    end

    // Memory port and decode outputs, decoded from registered state only
    always_comb begin
        req_state = (state_q == REQ_OP) || (state_q == REQ_LO) || (state_q == REQ_HI);
        case (state_q)
            REQ_LO:  req_addr = pc_q + ADDR_W'(1);
            REQ_HI:  req_addr = pc_q + ADDR_W'(2);
            default: req_addr = pc_q;
        endcase
        mem_req_o     = req_state && !rst_i;
        mem_addr_o    = mem_req_o ? req_addr : '0;
        dec_valid_o   = (state_q == ISSUE);
        dec_opcode_o  = dec_valid_o ? opcode_q     : '0;
        dec_operand_o = dec_valid_o ? {hi_q, lo_q} : '0;
        dec_len_o     = dec_valid_o ? len_q        : '0;
        dec_pc_o      = dec_valid_o ? pc_q         : '0;
        dec_illegal_o = dec_valid_o && illegal_q;
    end

endmodule

// File: doc/cpu_6502_fetch_sequencer.md
Name: cpu_6502_fetch_sequencer

Overview:
- Front-end controller for the 6502 core.
- Fetches the opcode byte, classifies it with the ISA package's implicit-opcode list and group/addressing-mode encodings, fetches 0–2 operand bytes, and presents one assembled instruction to decode/execute over a valid/ready handshake.
- Owns the program counter between redirects (branch/jump/interrupt) and is the sole master of the instruction-memory port.

Parameters:
- RESET_PC, 16'h8000, PC loaded on reset.
- ADDR_W, 16, address width; fixed by the ISA, only 16 is supported.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- mem_req_o  out  1  byte read request, held until granted
- mem_addr_o  out  16  read address, stable while mem_req_o=1
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid; earliest the cycle after gnt; one outstanding read max
- mem_rdata_i  in  8  read data
- dec_valid_o  out  1  instruction available
- dec_ready_i  in  1  consumer accepts
- dec_opcode_o  out  8  opcode byte
- dec_operand_o  out  16  {hi,lo} operand; unused bytes zero
- dec_len_o  out  2  instruction length, 1..3
- dec_pc_o  out  16  address of opcode byte
- dec_illegal_o  out  1  opcode not in the supported map
- redirect_i  in  1  load new PC, flush in-flight fetch
- redirect_pc_i  in  16  target PC

Behaviour:
- Reset (async assert, sync release): state REQ_OP, pc=RESET_PC. mem_req_o=0, dec_valid_o=0, dec_illegal_o=0; all data outputs 0. mem_req_o rises the first cycle after release.
- FSM states: REQ_OP, WAIT_OP, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, ISSUE, DRAIN.
- REQ_x: mem_req_o=1, mem_addr_o = pc, pc+1 or pc+2. On mem_gnt_i, go to WAIT_x.
- WAIT_x: on mem_rvalid_i, capture the byte.
  - WAIT_OP: compute len. len=1 goes to ISSUE; otherwise REQ_LO.
  - WAIT_LO: len=3 goes to REQ_HI; otherwise ISSUE.
  - WAIT_HI: goes to ISSUE.
- ISSUE: dec_valid_o=1; outputs held stable until dec_ready_i. On handshake, pc <= pc+len (mod 2^16, wraps FFFF→0000) and state <= REQ_OP.
- Length decode, cc=op[1:0], bbb=op[4:2]. Implicit opcodes are checked first.
  - Implicit list (BRK, RTI, RTS, PHP…SED, TXA…NOP): len 1.
  - JSR (8'h20): len 3.
  - Branch (op[4:0]=5'b10000): len 2.
  - cc=01 (group 1): bbb in {IND1_ZPG_X, ZPG, IMM, IND2_ZPG_Y, ZPG_X}: len 2. bbb in {ABS, ABS_Y, ABS_X}: len 3.
  - cc=10 (group 2): ACC: len 1. IMM/ZPG/ZPG_X: len 2. ABS/ABS_X: len 3.
  - cc=00 (group 3): IMM/ZPG/ZPG_X: len 2. ABS/ABS_X: len 3.
  - Anything else (incl. cc=11 and unlisted bbb): len 1, dec_illegal_o=1.
- Minimum latency with gnt in the request cycle and rvalid one cycle later: dec_valid_o is asserted 2/4/6 cycles after the first mem_req_o for len 1/2/3. Back-to-back issue period is len*2+1 cycles.
- Redirect has priority over all other events.
  - pc <= redirect_pc_i; any dec_valid_o drops next cycle.
  - In REQ_x without gnt: mem_req_o drops, next state REQ_OP.
  - Redirect in the same cycle as gnt, or in WAIT_x: go to DRAIN. DRAIN discards the next rvalid, then goes to REQ_OP.
  - Redirect in the same cycle as rvalid: that byte is discarded, next state REQ_OP.
  - Redirect in the same cycle as an ISSUE handshake: the handshake counts as consumed; pc takes redirect_pc_i, not pc+len.
  - A second redirect while in DRAIN updates pc only.
- Reset mid-fetch: immediate return to reset state. The memory model must also be reset; no drain is performed.
- No combinational path from dec_ready_i to mem_req_o/mem_addr_o.

Decomposition:
- Add to cpu_6502_ISA_pkg: a fetch_state_t enum; opcode field positions (CC, BBB, AAA slices); BRANCH_MASK/BRANCH_VAL; JSR = 8'h20.
- One combinational sub-module, cpu_6502_opcode_length (opcode → len, illegal), reused later by the disassembler and by the verification model.

Test Plan:
- Reset, then memory returns 8'hEA (NOP) at 8000 with gnt immediate and rvalid+1: dec_valid_o rises on cycle 2, len=1, pc=8000. With ready=1, the next request addr is 8001.
- Bytes AD 34 12 at 8000 (LDA abs): opcode=AD, operand=16'h1234, len=3, valid on cycle 6. The next fetch is at 8003.
- Bytes A9 05 (LDA imm) with dec_ready_i held low 5 cycles: all outputs stable, no mem_req_o during the stall. After ready, the next fetch is at 8002.
- Opcode 8'h02 (cc=10, bbb=000 under aaa=000 treated as legal IMM? no: ASL imm undefined) and 8'hFF: dec_illegal_o=1, len=1, pc advances by 1.
- PC=FFFE, bytes 8D 00 … fetched from FFFE, FFFF, 0000: operand hi is read from 0000, and the next pc is 0001.
- Redirect to C000 asserted the cycle after gnt of an operand fetch: stale rvalid data is ignored, and the next mem_addr_o is C000. Redirect coincident with an ISSUE handshake: the next fetch is at C000, not pc+len.
